// File: rtl/decode_mux.sv
`default_nettype none
// ============================================================================
// Module   : decode_mux
// Purpose  : Registered 3:1 merge of the A/B/D-format decoder outputs into one
//            unified instruction record with a normalised 64-bit body.
// Revision : 1.0 - initial release
// ============================================================================
// Vector bit 0 is the architectural MSB, so architectural body_o[0:k] maps onto
// the numeric top bits body_o[63:63-k] of the descending-range ports below.
module decode_mux #(
  parameter int ADDRESS_WIDTH             = 64,
  parameter int PID_SIZE                  = 20,
  parameter int TID_SIZE                  = 16,
  parameter int INSTRUCTION_COUNTER_WIDTH = 64,
  parameter int INST_MIN_ID_WIDTH         = 7,
  parameter int OPCODE_SIZE               = 12,
  parameter int REG_SIZE                  = 5,
  parameter int REG_ACCESS_PATTERN_SIZE   = 2,
  parameter int FUNC_UNIT_CODE_SIZE       = 3,
  parameter int B_IMMEDIATE_SIZE          = 14,
  parameter int D_IMMEDIATE_SIZE          = 16
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  // A format
  input  logic                                 Aenable_i,
  input  logic [OPCODE_SIZE-1:0]               AOpcode_i,
  input  logic [ADDRESS_WIDTH-1:0]             AAddress_i,
  input  logic [FUNC_UNIT_CODE_SIZE-1:0]       AUnitType_i,
  input  logic [INSTRUCTION_COUNTER_WIDTH-1:0] AMajId_i,
  input  logic [INST_MIN_ID_WIDTH-1:0]         AMinId_i,
  input  logic [INST_MIN_ID_WIDTH-1:0]         AnumMicroOps_i,
  input  logic                                 Ais64Bit_i,
  input  logic [PID_SIZE-1:0]                  APid_i,
  input  logic [TID_SIZE-1:0]                  ATid_i,
  input  logic [REG_ACCESS_PATTERN_SIZE-1:0]   Aop1rw_i,
  input  logic [REG_ACCESS_PATTERN_SIZE-1:0]   Aop2rw_i,
  input  logic [REG_ACCESS_PATTERN_SIZE-1:0]   Aop3rw_i,
  input  logic [REG_ACCESS_PATTERN_SIZE-1:0]   Aop4rw_i,
  input  logic                                 Aop1IsReg_i,
  input  logic                                 Aop2IsReg_i,
  input  logic                                 Aop3IsReg_i,
  input  logic                                 Aop4IsReg_i,
  input  logic [4*REG_SIZE:0]                  ABody_i,
  // B format
  input  logic                                 Benable_i,
  input  logic [OPCODE_SIZE-1:0]               BOpcode_i,
  input  logic [ADDRESS_WIDTH-1:0]             BAddress_i,
  input  logic [FUNC_UNIT_CODE_SIZE-1:0]       BUnitType_i,
  input  logic [INSTRUCTION_COUNTER_WIDTH-1:0] BMajId_i,
  input  logic [INST_MIN_ID_WIDTH-1:0]         BMinId_i,
  input  logic [INST_MIN_ID_WIDTH-1:0]         BnumMicroOps_i,
  input  logic                                 Bis64Bit_i,
  input  logic [PID_SIZE-1:0]                  BPid_i,
  input  logic [TID_SIZE-1:0]                  BTid_i,
  input  logic [2*REG_SIZE+B_IMMEDIATE_SIZE+3:0] BBody_i,
  // D format
  input  logic                                 Denable_i,
  input  logic [OPCODE_SIZE-1:0]               DOpcode_i,
  input  logic [ADDRESS_WIDTH-1:0]             DAddress_i,
  input  logic [FUNC_UNIT_CODE_SIZE-1:0]       DUnitType_i,
  input  logic [INSTRUCTION_COUNTER_WIDTH-1:0] DMajId_i,
  input  logic [INST_MIN_ID_WIDTH-1:0]         DMinId_i,
  input  logic [INST_MIN_ID_WIDTH-1:0]         DnumMicroOps_i,
  input  logic                                 Dis64Bit_i,
  input  logic [PID_SIZE-1:0]                  DPid_i,
  input  logic [TID_SIZE-1:0]                  DTid_i,
  input  logic [REG_ACCESS_PATTERN_SIZE-1:0]   Dop1rw_i,
  input  logic [REG_ACCESS_PATTERN_SIZE-1:0]   Dop2rw_i,
  input  logic                                 Dop1isReg_i,
  input  logic                                 Dop2isReg_i,
  input  logic                                 immIsExtended_i,
  input  logic                                 immIsShifted_i,
  input  logic [2:0]                           shiftedBy_i,
  input  logic [2*REG_SIZE+D_IMMEDIATE_SIZE-1:0] DBody_i,
  // Unified output
  output logic                                 enable_o,
  output logic [OPCODE_SIZE-1:0]               opcode_o,
  output logic [ADDRESS_WIDTH-1:0]             address_o,
  output logic [FUNC_UNIT_CODE_SIZE-1:0]       funcUnitType_o,
  output logic [INSTRUCTION_COUNTER_WIDTH-1:0] majID_o,
  output logic [INST_MIN_ID_WIDTH-1:0]         minID_o,
  output logic [INST_MIN_ID_WIDTH-1:0]         numMicroOps_o,
  output logic                                 is64Bit_o,
  output logic [PID_SIZE-1:0]                  pid_o,
  output logic [TID_SIZE-1:0]                  tid_o,
  output logic [REG_ACCESS_PATTERN_SIZE-1:0]   op1rw_o,
  output logic [REG_ACCESS_PATTERN_SIZE-1:0]   op2rw_o,
  output logic [REG_ACCESS_PATTERN_SIZE-1:0]   op3rw_o,
  output logic [REG_ACCESS_PATTERN_SIZE-1:0]   op4rw_o,
  output logic                                 op1IsReg_o,
  output logic                                 op2IsReg_o,
  output logic                                 op3IsReg_o,
  output logic                                 op4IsReg_o,
  output logic [63:0]                          body_o
);

  localparam int C_BODY_W      = 64;
  localparam int C_A_BODY_W    = 4*REG_SIZE + 1;
  localparam int C_B_BODY_W    = 2*REG_SIZE + B_IMMEDIATE_SIZE + 4;
  localparam int C_D_REGS_W    = 2*REG_SIZE;
  localparam int C_D_IMM_W     = C_BODY_W - C_D_REGS_W;
  localparam int C_D_IMM_PAD_W = C_D_IMM_W - D_IMMEDIATE_SIZE;
  localparam int C_RW_W        = REG_ACCESS_PATTERN_SIZE;

  // D-format immediate normalisation
  logic [D_IMMEDIATE_SIZE-1:0] w_d_imm;
  logic [C_D_IMM_W-1:0]        w_d_imm_ext;
  logic [C_D_IMM_W-1:0]        w_d_imm_field;
  logic [8:0]                  w_d_shift_amt;
  logic [C_BODY_W-1:0]         w_body_a;
  logic [C_BODY_W-1:0]         w_body_b;
  logic [C_BODY_W-1:0]         w_body_d;

  assign w_d_imm     = DBody_i[D_IMMEDIATE_SIZE-1:0];
  assign w_d_imm_ext = immIsExtended_i
                     ? {{C_D_IMM_PAD_W{w_d_imm[D_IMMEDIATE_SIZE-1]}}, w_d_imm}
                     : {{C_D_IMM_PAD_W{1'b0}}, w_d_imm};
  // Shift distance is a power of two; distances past the field width flush it to zero.
  assign w_d_shift_amt = 9'd1 << shiftedBy_i;
  assign w_d_imm_field = immIsShifted_i ? (w_d_imm_ext << w_d_shift_amt) : w_d_imm_ext;

  assign w_body_a = {ABody_i, {(C_BODY_W-C_A_BODY_W){1'b0}}};
  assign w_body_b = {BBody_i, {(C_BODY_W-C_B_BODY_W){1'b0}}};
  assign w_body_d = {DBody_i[C_D_REGS_W+D_IMMEDIATE_SIZE-1:D_IMMEDIATE_SIZE], w_d_imm_field};

  logic                                 enable_q,       enable_d;
  logic [OPCODE_SIZE-1:0]               opcode_q,       opcode_d;
  logic [ADDRESS_WIDTH-1:0]             address_q,      address_d;
  logic [FUNC_UNIT_CODE_SIZE-1:0]       unit_q,         unit_d;
  logic [INSTRUCTION_COUNTER_WIDTH-1:0] maj_id_q,       maj_id_d;
  logic [INST_MIN_ID_WIDTH-1:0]         min_id_q,       min_id_d;
  logic [INST_MIN_ID_WIDTH-1:0]         num_uops_q,     num_uops_d;
  logic                                 is64_q,         is64_d;
  logic [PID_SIZE-1:0]                  pid_q,          pid_d;
  logic [TID_SIZE-1:0]                  tid_q,          tid_d;
  logic [C_RW_W-1:0]                    op1rw_q,        op1rw_d;
  logic [C_RW_W-1:0]                    op2rw_q,        op2rw_d;
  logic [C_RW_W-1:0]                    op3rw_q,        op3rw_d;
  logic [C_RW_W-1:0]                    op4rw_q,        op4rw_d;
  logic [3:0]                           is_reg_q,       is_reg_d;
  logic [C_BODY_W-1:0]                  body_q,         body_d;

  // Fixed priority A > B > D; with no enable only the valid flag drops.
  always_comb begin
    enable_d   = 1'b0;
    opcode_d   = opcode_q;
    address_d  = address_q;
    unit_d     = unit_q;
    maj_id_d   = maj_id_q;
    min_id_d   = min_id_q;
    num_uops_d = num_uops_q;
    is64_d     = is64_q;
    pid_d      = pid_q;
    tid_d      = tid_q;
    op1rw_d    = op1rw_q;
    op2rw_d    = op2rw_q;
    op3rw_d    = op3rw_q;
    op4rw_d    = op4rw_q;
    is_reg_d   = is_reg_q;
    body_d     = body_q;
    if (Aenable_i) begin
      enable_d   = 1'b1;
      opcode_d   = AOpcode_i;
      address_d  = AAddress_i;
      unit_d     = AUnitType_i;
      maj_id_d   = AMajId_i;
      min_id_d   = AMinId_i;
      num_uops_d = AnumMicroOps_i;
      is64_d     = Ais64Bit_i;
      pid_d      = APid_i;
      tid_d      = ATid_i;
      op1rw_d    = Aop1rw_i;
      op2rw_d    = Aop2rw_i;
      op3rw_d    = Aop3rw_i;
      op4rw_d    = Aop4rw_i;
      is_reg_d   = {Aop1IsReg_i, Aop2IsReg_i, Aop3IsReg_i, Aop4IsReg_i};
      body_d     = w_body_a;
    end else if (Benable_i) begin
      enable_d   = 1'b1;
      opcode_d   = BOpcode_i;
      address_d  = BAddress_i;
      unit_d     = BUnitType_i;
      maj_id_d   = BMajId_i;
      min_id_d   = BMinId_i;
      num_uops_d = BnumMicroOps_i;
      is64_d     = Bis64Bit_i;
      pid_d      = BPid_i;
      tid_d      = BTid_i;
      op1rw_d    = '0;
      op2rw_d    = '0;
      op3rw_d    = '0;
      op4rw_d    = '0;
      is_reg_d   = 4'b0000;
      body_d     = w_body_b;
    end else if (Denable_i) begin
      enable_d   = 1'b1;
      opcode_d   = DOpcode_i;
      address_d  = DAddress_i;
      unit_d     = DUnitType_i;
      maj_id_d   = DMajId_i;
      min_id_d   = DMinId_i;
      num_uops_d = DnumMicroOps_i;
      is64_d     = Dis64Bit_i;
      pid_d      = DPid_i;
      tid_d      = DTid_i;
      op1rw_d    = Dop1rw_i;
      op2rw_d    = Dop2rw_i;
      op3rw_d    = '0;
      op4rw_d    = '0;
      is_reg_d   = {Dop1isReg_i, Dop2isReg_i, 2'b00};
      body_d     = w_body_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      enable_q   <= 1'b0;
      opcode_q   <= '0;
      address_q  <= '0;
      unit_q     <= '0;
      maj_id_q   <= '0;
      min_id_q   <= '0;
      num_uops_q <= '0;
      is64_q     <= 1'b0;
      pid_q      <= '0;
      tid_q      <= '0;
      op1rw_q    <= '0;
      op2rw_q    <= '0;
      op3rw_q    <= '0;
      op4rw_q    <= '0;
      is_reg_q   <= '0;
      body_q     <= '0;
    end else begin
      enable_q   <= enable_d;
      opcode_q   <= opcode_d;
      address_q  <= address_d;
      unit_q     <= unit_d;
      maj_id_q   <= maj_id_d;
      min_id_q   <= min_id_d;
      num_uops_q <= num_uops_d;
      is64_q     <= is64_d;
      pid_q      <= pid_d;
      tid_q      <= tid_d;
      op1rw_q    <= op1rw_d;
      op2rw_q    <= op2rw_d;
      op3rw_q    <= op3rw_d;
      op4rw_q    <= op4rw_d;
      is_reg_q   <= is_reg_d;
      body_q     <= body_d;
    end
  end

  assign enable_o       = enable_q;
  assign opcode_o       = opcode_q;
  assign address_o      = address_q;
  assign funcUnitType_o = unit_q;
  assign majID_o        = maj_id_q;
  assign minID_o        = min_id_q;
  assign numMicroOps_o  = num_uops_q;
  assign is64Bit_o      = is64_q;
  assign pid_o          = pid_q;
  assign tid_o          = tid_q;
  assign op1rw_o        = op1rw_q;
  assign op2rw_o        = op2rw_q;
  assign op3rw_o        = op3rw_q;
  assign op4rw_o        = op4rw_q;
  assign op1IsReg_o     = is_reg_q[3];
  assign op2IsReg_o     = is_reg_q[2];
  assign op3IsReg_o     = is_reg_q[1];
  assign op4IsReg_o     = is_reg_q[0];
  assign body_o         = body_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_mux
// Purpose  : Table-driven self-checking bench for decode_mux with a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic        Aenable_i, Benable_i, Denable_i;
  logic [11:0] AOpcode_i, BOpcode_i, DOpcode_i;
  logic [63:0] AAddress_i, BAddress_i, DAddress_i;
  logic [2:0]  AUnitType_i, BUnitType_i, DUnitType_i;
  logic [63:0] AMajId_i, BMajId_i, DMajId_i;
  logic [6:0]  AMinId_i, BMinId_i, DMinId_i;
  logic [6:0]  AnumMicroOps_i, BnumMicroOps_i, DnumMicroOps_i;
  logic        Ais64Bit_i, Bis64Bit_i, Dis64Bit_i;
  logic [19:0] APid_i, BPid_i, DPid_i;
  logic [15:0] ATid_i, BTid_i, DTid_i;
  logic [1:0]  Aop1rw_i, Aop2rw_i, Aop3rw_i, Aop4rw_i;
  logic        Aop1IsReg_i, Aop2IsReg_i, Aop3IsReg_i, Aop4IsReg_i;
  logic [20:0] ABody_i;
  logic [27:0] BBody_i;
  logic [1:0]  Dop1rw_i, Dop2rw_i;
  logic        Dop1isReg_i, Dop2isReg_i;
  logic        immIsExtended_i, immIsShifted_i;
  logic [2:0]  shiftedBy_i;
  logic [25:0] DBody_i;

  logic        enable_o, is64Bit_o;
  logic [11:0] opcode_o;
  logic [63:0] address_o, majID_o, body_o;
  logic [2:0]  funcUnitType_o;
  logic [6:0]  minID_o, numMicroOps_o;
  logic [19:0] pid_o;
  logic [15:0] tid_o;
  logic [1:0]  op1rw_o, op2rw_o, op3rw_o, op4rw_o;
  logic        op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;

  decode_mux dut (
    .clock_i(clk), .reset_i(reset_i),
    .Aenable_i(Aenable_i), .AOpcode_i(AOpcode_i), .AAddress_i(AAddress_i), .AUnitType_i(AUnitType_i),
    .AMajId_i(AMajId_i), .AMinId_i(AMinId_i), .AnumMicroOps_i(AnumMicroOps_i), .Ais64Bit_i(Ais64Bit_i),
    .APid_i(APid_i), .ATid_i(ATid_i),
    .Aop1rw_i(Aop1rw_i), .Aop2rw_i(Aop2rw_i), .Aop3rw_i(Aop3rw_i), .Aop4rw_i(Aop4rw_i),
    .Aop1IsReg_i(Aop1IsReg_i), .Aop2IsReg_i(Aop2IsReg_i), .Aop3IsReg_i(Aop3IsReg_i), .Aop4IsReg_i(Aop4IsReg_i),
    .ABody_i(ABody_i),
    .Benable_i(Benable_i), .BOpcode_i(BOpcode_i), .BAddress_i(BAddress_i), .BUnitType_i(BUnitType_i),
    .BMajId_i(BMajId_i), .BMinId_i(BMinId_i), .BnumMicroOps_i(BnumMicroOps_i), .Bis64Bit_i(Bis64Bit_i),
    .BPid_i(BPid_i), .BTid_i(BTid_i), .BBody_i(BBody_i),
    .Denable_i(Denable_i), .DOpcode_i(DOpcode_i), .DAddress_i(DAddress_i), .DUnitType_i(DUnitType_i),
    .DMajId_i(DMajId_i), .DMinId_i(DMinId_i), .DnumMicroOps_i(DnumMicroOps_i), .Dis64Bit_i(Dis64Bit_i),
    .DPid_i(DPid_i), .DTid_i(DTid_i),
    .Dop1rw_i(Dop1rw_i), .Dop2rw_i(Dop2rw_i), .Dop1isReg_i(Dop1isReg_i), .Dop2isReg_i(Dop2isReg_i),
    .immIsExtended_i(immIsExtended_i), .immIsShifted_i(immIsShifted_i), .shiftedBy_i(shiftedBy_i),
    .DBody_i(DBody_i),
    .enable_o(enable_o), .opcode_o(opcode_o), .address_o(address_o), .funcUnitType_o(funcUnitType_o),
    .majID_o(majID_o), .minID_o(minID_o), .numMicroOps_o(numMicroOps_o), .is64Bit_o(is64Bit_o),
    .pid_o(pid_o), .tid_o(tid_o),
    .op1rw_o(op1rw_o), .op2rw_o(op2rw_o), .op3rw_o(op3rw_o), .op4rw_o(op4rw_o),
    .op1IsReg_o(op1IsReg_o), .op2IsReg_o(op2IsReg_o), .op3IsReg_o(op3IsReg_o), .op4IsReg_o(op4IsReg_o),
    .body_o(body_o)
  );

  typedef struct packed {
    logic        en;
    logic [11:0] opc;
    logic [63:0] addr;
    logic [2:0]  unit;
    logic [63:0] maj;
    logic [6:0]  min;
    logic [6:0]  nmo;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [7:0]  rw;
    logic [3:0]  isreg;
    logic [63:0] body;
  } out_t;

  // Inputs, then expected outputs; xfmt 0/1/2 = A/B/D metadata, 3 = all-zero metadata.
  typedef struct {
    logic        rst, aen, ben, den;
    logic [11:0] oa, ob, od;
    logic [7:0]  arw;
    logic [3:0]  areg;
    logic [20:0] abody;
    logic [27:0] bbody;
    logic [3:0]  drw;
    logic [1:0]  dreg;
    logic        ext, shf;
    logic [2:0]  shby;
    logic [25:0] dbody;
    logic        xen;
    logic [1:0]  xfmt;
    logic [11:0] xopc;
    logic [7:0]  xrw;
    logic [3:0]  xreg;
    logic [63:0] xbody;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t sb[$];

  // Per-format metadata pattern, distinct for every (format, opcode) pair.
  function automatic out_t meta(input logic [1:0] f, input logic [11:0] opc);
    out_t m = '0;
    m.addr = {opc, f, 50'h25A5A12345678};
    m.unit = opc[2:0] ^ {1'b0, f} ^ 3'd5;
    m.maj  = {opc, 50'h0, f} ^ 64'h8000_0000_0000_0001;
    m.min  = opc[6:0] + {5'b0, f};
    m.nmo  = opc[6:0] ^ 7'h55 ^ {5'b0, f};
    m.is64 = ~opc[0] ^ f[0];
    m.pid  = {opc, 6'b0, f};
    m.tid  = {opc[3:0], 10'h2A5, f};
    return m;
  endfunction

  function automatic out_t expect_of(input vec_t v);
    out_t e = (v.xfmt == 2'd3) ? '0 : meta(v.xfmt, v.xopc);
    e.en    = v.xen;
    e.opc   = v.xopc;
    e.rw    = v.xrw;
    e.isreg = v.xreg;
    e.body  = v.xbody;
    return e;
  endfunction

  // Immediate reference: arithmetic multiply by 2**(2**s), kept to 54 bits.
  function automatic logic [53:0] d_model(input logic [15:0] imm, input logic ext,
                                          input logic shf, input int s);
    logic [127:0] e, p;
    e = ext ? {{112{imm[15]}}, imm} : {112'b0, imm};
    p = shf ? e * (128'd1 << (1 << s)) : e;
    return p[53:0];
  endfunction

  function automatic out_t read_dut();
    return {enable_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o, numMicroOps_o,
            is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
            op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o};
  endfunction

  task automatic drive(input vec_t v);
    out_t m;
    reset_i = v.rst;
    Aenable_i = v.aen; Benable_i = v.ben; Denable_i = v.den;
    m = meta(2'd0, v.oa);
    AOpcode_i = v.oa; AAddress_i = m.addr; AUnitType_i = m.unit; AMajId_i = m.maj;
    AMinId_i = m.min; AnumMicroOps_i = m.nmo; Ais64Bit_i = m.is64; APid_i = m.pid; ATid_i = m.tid;
    {Aop1rw_i, Aop2rw_i, Aop3rw_i, Aop4rw_i} = v.arw;
    {Aop1IsReg_i, Aop2IsReg_i, Aop3IsReg_i, Aop4IsReg_i} = v.areg;
    ABody_i = v.abody;
    m = meta(2'd1, v.ob);
    BOpcode_i = v.ob; BAddress_i = m.addr; BUnitType_i = m.unit; BMajId_i = m.maj;
    BMinId_i = m.min; BnumMicroOps_i = m.nmo; Bis64Bit_i = m.is64; BPid_i = m.pid; BTid_i = m.tid;
    BBody_i = v.bbody;
    m = meta(2'd2, v.od);
    DOpcode_i = v.od; DAddress_i = m.addr; DUnitType_i = m.unit; DMajId_i = m.maj;
    DMinId_i = m.min; DnumMicroOps_i = m.nmo; Dis64Bit_i = m.is64; DPid_i = m.pid; DTid_i = m.tid;
    {Dop1rw_i, Dop2rw_i} = v.drw;
    {Dop1isReg_i, Dop2isReg_i} = v.dreg;
    immIsExtended_i = v.ext; immIsShifted_i = v.shf; shiftedBy_i = v.shby;
    DBody_i = v.dbody;
  endtask

  task automatic apply(input vec_t v, input string name);
    out_t got, exp;
    drive(v);
    sb.push_back(expect_of(v));
    @(posedge clk);
    #1;
    got = read_dut();
    exp = sb.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  localparam logic [20:0] AB  = 21'b10001_01110_11111_00000_1;
  localparam logic [63:0] AX  = 64'h8BBE_0800_0000_0000;
  localparam logic [9:0]  R10 = 10'b00011_00100;
  localparam logic [63:0] BX  = {28'hABCDEF1, 36'h0};

  vec_t vecs[16];
  vec_t v;

  initial begin
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 12'd0,12'd0,12'd0, 8'h00,4'h0,21'h0,28'h0, 4'h0,2'b00,1'b0,1'b0,3'd0,26'h0,
                 1'b0,2'd3,12'd0, 8'h00,4'h0,64'h0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0, 12'd4,12'd7,12'd8, 8'b01_10_00_10,4'b1101,AB,28'h1234567, 4'b1001,2'b10,1'b0,1'b0,3'd0,26'h0,
                 1'b1,2'd0,12'd4, 8'b01_10_00_10,4'b1101,AX};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0, 12'd9,12'd7,12'd8, 8'hFF,4'hF,21'h1,28'h1, 4'hF,2'b11,1'b1,1'b1,3'd7,26'h3FFFFFF,
                 1'b0,2'd0,12'd4, 8'b01_10_00_10,4'b1101,AX};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1, 12'd5,12'd6,12'd3, 8'hFF,4'hF,21'h0,28'h0, 4'b1001,2'b10,1'b1,1'b1,3'd4,{R10,16'hFFFE},
                 1'b1,2'd2,12'd3, 8'b10_01_00_00,4'b1000,{R10,54'h3FFFFFFFFE0000}};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1, 12'd5,12'd6,12'd3, 8'hFF,4'hF,21'h0,28'h0, 4'b1001,2'b10,1'b0,1'b0,3'd4,{R10,16'hFFFE},
                 1'b1,2'd2,12'd3, 8'b10_01_00_00,4'b1000,{R10,54'h000000000FFFE}};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0, 12'd5,12'd2,12'd6, 8'hFF,4'hF,21'h0,28'hABCDEF1, 4'hF,2'b11,1'b0,1'b0,3'd0,26'h0,
                 1'b1,2'd1,12'd2, 8'h00,4'h0,BX};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b1, 12'd1,12'd2,12'd3, 8'b10_01_10_00,4'b0110,AB,28'hABCDEF1, 4'b0110,2'b01,1'b0,1'b0,3'd0,{R10,16'h1234},
                 1'b1,2'd0,12'd1, 8'b10_01_10_00,4'b0110,AX};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b1, 12'd1,12'd2,12'd3, 8'b10_01_10_00,4'b0110,AB,28'hABCDEF1, 4'b0110,2'b01,1'b0,1'b0,3'd0,{R10,16'h1234},
                 1'b1,2'd1,12'd2, 8'h00,4'h0,BX};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1, 12'd1,12'd2,12'd3, 8'b10_01_10_00,4'b0110,AB,28'hABCDEF1, 4'b0110,2'b01,1'b0,1'b0,3'd0,{R10,16'h1234},
                 1'b1,2'd2,12'd3, 8'b01_10_00_00,4'b0100,{R10,54'h1234}};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1, 12'd0,12'd0,12'h0AB, 8'h00,4'h0,21'h0,28'h0, 4'b1010,2'b11,1'b1,1'b1,3'd6,{R10,16'h8001},
                 1'b1,2'd2,12'h0AB, 8'b10_10_00_00,4'b1100,{R10,54'h0}};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1, 12'd0,12'd0,12'h0AC, 8'h00,4'h0,21'h0,28'h0, 4'b1010,2'b11,1'b0,1'b1,3'd5,{R10,16'h8001},
                 1'b1,2'd2,12'h0AC, 8'b10_10_00_00,4'b1100,{R10,54'h800100000000}};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1, 12'd0,12'd0,12'h0AD, 8'h00,4'h0,21'h0,28'h0, 4'b1010,2'b11,1'b1,1'b1,3'd0,{R10,16'h8000},
                 1'b1,2'd2,12'h0AD, 8'b10_10_00_00,4'b1100,{R10,54'h3FFFFFFFFF0000}};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1, 12'd0,12'd0,12'h0AE, 8'h00,4'h0,21'h0,28'h0, 4'b1010,2'b11,1'b0,1'b1,3'd7,{R10,16'h7FFF},
                 1'b1,2'd2,12'h0AE, 8'b10_10_00_00,4'b1100,{R10,54'h0}};
    vecs[13] = '{1'b1,1'b1,1'b0,1'b0, 12'd4,12'd7,12'd8, 8'b01_10_00_10,4'b1101,AB,28'h1234567, 4'b1001,2'b10,1'b0,1'b0,3'd0,26'h0,
                 1'b0,2'd3,12'd0, 8'h00,4'h0,64'h0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0, 12'd4,12'd7,12'd8, 8'b01_10_00_10,4'b1101,AB,28'h1234567, 4'b1001,2'b10,1'b0,1'b0,3'd0,26'h0,
                 1'b0,2'd3,12'd0, 8'h00,4'h0,64'h0};
    vecs[15] = '{1'b0,1'b1,1'b0,1'b0, 12'hFFF,12'd7,12'd8, 8'b11_11_11_11,4'b1111,21'h1FFFFF,28'h0, 4'h0,2'b00,1'b0,1'b0,3'd0,26'h0,
                 1'b1,2'd0,12'hFFF, 8'b11_11_11_11,4'b1111,64'hFFFF_F800_0000_0000};

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back D instructions sweeping every shift exponent, alternating extension.
    for (int s = 0; s < 8; s++) begin
      v = vecs[14];
      v.aen   = 1'b0;
      v.den   = 1'b1;
      v.od    = 12'h100 + 12'(s);
      v.drw   = 4'b0101;
      v.dreg  = 2'b01;
      v.ext   = s[0];
      v.shf   = 1'b1;
      v.shby  = 3'(s);
      v.dbody = {10'h2B5, 16'hC3A5};
      v.xen   = 1'b1;
      v.xfmt  = 2'd2;
      v.xopc  = v.od;
      v.xrw   = 8'b01_01_00_00;
      v.xreg  = 4'b0100;
      v.xbody = {10'h2B5, d_model(16'hC3A5, s[0], 1'b1, s)};
      apply(v, $sformatf("dshift%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_mux.md
Name: decode_mux

Overview:
- Registered 3:1 merge point of the decode stage: collects the outputs of the A-, B- and D-format decoders and forwards one instruction per cycle to the next pipeline stage in a single unified format.
- Operand descriptors and the instruction body are normalised into one 64-bit body field.
- One cycle of latency.

Parameters:
addressWidth, 64, instruction address width
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major instruction ID width
instMinIdWidth, 7, minor ID / micro-op count width
opcodeSize, 12, internal opcode width
regSize, 5, register field width
regAccessPatternSize, 2, operand access code width (bit0 = read, bit1 = write; 2'b10 read, 2'b01 write)
funcUnitCodeSize, 3, functional unit code width
BimmediateSize, 14, B-format displacement width
DimmediateSize, 16, D-format immediate width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clock_i  in  1  clock
  - reset_i  in  1  synchronous active-high reset
- Common input group, repeated for each prefix X in {A, B, D} (Aenable_i, BOpcode_i, DPid_i, ...):
  - Xenable_i  in  1  format X instruction valid
  - XOpcode_i  in  opcodeSize  opcode
  - XAddress_i  in  addressWidth  instruction address
  - XUnitType_i  in  funcUnitCodeSize  target functional unit
  - XMajId_i  in  instructionCounterWidth  major ID
  - XMinId_i, XnumMicroOps_i  in  instMinIdWidth each  minor ID, micro-op count
  - Xis64Bit_i  in  1  64-bit mode
  - XPid_i  in  PidSize  process ID
  - XTid_i  in  TidSize  thread ID
- A-format specific inputs:
  - Aop1rw_i..Aop4rw_i  in  2 each  A operand access codes
  - Aop1IsReg_i..Aop4IsReg_i  in  1 each  A operand is a register
  - ABody_i  in  4*regSize+1 (21)  four register fields plus Rc bit
- B-format specific inputs:
  - BBody_i  in  2*regSize+BimmediateSize+4 (28)  BO, BI, BD, AA/LK/spare bits
- D-format specific inputs:
  - Dop1rw_i, Dop2rw_i  in  2 each  D operand access codes
  - Dop1isReg_i, Dop2isReg_i  in  1 each  D operand is a register
  - immIsExtended_i  in  1  sign-extend the immediate
  - immIsShifted_i  in  1  shift the immediate
  - shiftedBy_i  in  3  shift exponent
  - DBody_i  in  2*regSize+DimmediateSize (26)  two register fields then the immediate
- Outputs (all registered):
  - enable_o  out  1  output valid
  - opcode_o, address_o, funcUnitType_o, majID_o, minID_o, numMicroOps_o, is64Bit_o, pid_o, tid_o  out  same widths as the corresponding inputs  selected metadata
  - op1rw_o..op4rw_o  out  2 each  operand access codes
  - op1IsReg_o..op4IsReg_o  out  1 each  operand is a register
  - body_o  out  64  normalised body

Behaviour:
- Bit 0 is the MSB of every vector.
- All outputs update on the rising edge of clock_i; latency is 1 cycle.
- Reset: when reset_i=1 at an edge, every output is cleared to 0 and enable_o=0. Reset takes precedence over any enable.
- Selection priority is A > B > D. When more than one enable is high, only the highest-priority format is forwarded and the others are dropped.
- No enable high: enable_o=0 at the next edge; all other outputs hold their previous values.
- Selected format: enable_o=1, and all common metadata is copied from that format's inputs.
- A selected:
  - opNrw_o = AopNrw_i, opNIsReg_o = AopNIsReg_i.
  - body_o[0:20] = ABody_i; body_o[21:63] = 0.
- B selected:
  - All opNrw_o = 00, all opNIsReg_o = 0.
  - body_o[0:27] = BBody_i; body_o[28:63] = 0.
- D selected:
  - op1/op2 access codes and isReg flags are taken from the D inputs; op3/op4 rw = 00, isReg = 0.
  - body_o[0:9] = DBody_i[0:9] (the two register fields).
  - body_o[10:63] is a 54-bit immediate field, built from imm = DBody_i[10:25]:
    - Zero-extend imm to 54 bits, or sign-extend it (copy of DBody_i[10]) if immIsExtended_i=1.
    - If immIsShifted_i=1, then shift left logically by 2**shiftedBy_i bits, truncated to 54 bits. Shifts of 64 or 128 yield 0.
- Back-to-back enables produce back-to-back outputs; there is no stall or backpressure.

Test Plan:
- Reset: pulse reset_i=1 for one edge with all inputs at 0 -> every output 0, enable_o=0.
- A format:
  - Stimulus: Aenable_i=1, AOpcode_i=4, AUnitType_i=1, Ais64Bit_i=1; op rw = 01,10,00,10; isReg = 1,1,0,1; ABody_i=21'b10001_01110_11111_00000_1.
  - Response after one edge: enable_o=1, opcode_o=4, funcUnitType_o=1, is64Bit_o=1, rw/isReg copied, body_o[0:20] equal to ABody_i, body_o[21:63]=0.
  - Drop Aenable_i -> enable_o=0 at the next edge, other outputs held.
- D format, sign-extend and shift:
  - Stimulus: DBody_i = regs 00011_00100, imm 16'hFFFE; immIsExtended_i=1, immIsShifted_i=1, shiftedBy_i=4.
  - Response: body_o[0:9]=0001100100, body_o[10:63] = -2<<16 as 54-bit two's complement.
  - Same stimulus with immIsExtended_i=0, immIsShifted_i=0 -> body_o[10:63] = 54'h000000000FFFE.
- B format: BBody_i = 28'hABCDEF1 -> body_o[0:27]=28'hABCDEF1, body_o[28:63]=0, all rw=00, all isReg=0.
- Priority: A, B and D enabled in the same cycle with distinct opcodes 1/2/3 -> opcode_o=1. Drop Aenable_i -> opcode_o=2. Drop Benable_i -> opcode_o=3.
- Reset mid-stream: Aenable_i=1 together with reset_i=1 -> enable_o=0 and all outputs 0.
